// File: rtl/booth_mul_arbiter_if.sv
// Bundle of requester, response and multiplier-side signals for booth_mul_arbiter.
// slave is the arbiter's view; master is the environment (requesters plus multiplier).
interface booth_mul_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 128
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_a;
  logic [N*WIDTH-1:0] req_b;
  logic [N-1:0]       req_ready;
  logic               resp_valid;
  logic [IDW-1:0]     resp_id;
  logic [2*WIDTH-1:0] resp_ab;
  logic               resp_err;
  logic               busy;
  logic               mul_reset;
  logic               mul_enable;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0] mul_ab;
  logic               mul_done;

  modport slave (
    input  req_valid, req_a, req_b, mul_ab, mul_done,
    output req_ready, resp_valid, resp_id, resp_ab, resp_err, busy,
           mul_reset, mul_enable, mul_a, mul_b
  );

  modport master (
    output req_valid, req_a, req_b, mul_ab, mul_done,
    input  req_ready, resp_valid, resp_id, resp_ab, resp_err, busy,
           mul_reset, mul_enable, mul_a, mul_b
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier among N requesters:
// grant, pulse multiplier reset, run until done or timeout, return the product.
module booth_mul_arbiter #(
  parameter int N       = 4,
  parameter int WIDTH   = 128,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  booth_mul_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(N);
  localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_RESP} state_t;

  state_t             r_state;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_sel;
  logic [IDW-1:0]     r_resp_id;
  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  logic [2*WIDTH-1:0] r_resp_ab;
  logic               r_resp_err;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH-1:0]   w_a [N];
  logic [WIDTH-1:0]   w_b [N];
  logic               w_found;
  logic [IDW-1:0]     w_win;
  logic [IDW-1:0]     w_idx;
  logic [IDW:0]       w_sum;
  logic [IDW-1:0]     w_ptr_next;
  logic               w_timeout;

  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign w_a[gi] = bus.req_a[gi*WIDTH +: WIDTH];
    assign w_b[gi] = bus.req_b[gi*WIDTH +: WIDTH];
  end

  // Scan from the pointer upward, wrapping without a modulo operator.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      w_idx = (w_sum >= (IDW+1)'(N)) ? IDW'(w_sum - (IDW+1)'(N)) : IDW'(w_sum);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_ptr_next = (w_win == IDW'(N - 1)) ? '0 : w_win + 1'b1;
  assign w_timeout  = TO_EN && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_sel      <= '0;
      r_resp_id  <= '0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_resp_ab  <= '0;
      r_resp_err <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_mul_a <= w_a[w_win];
            r_mul_b <= w_b[w_win];
            r_sel   <= w_win;
            r_ptr   <= w_ptr_next;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_cnt   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          // A done arriving on the timeout cycle still counts as success.
          if (bus.mul_done) begin
            r_resp_ab  <= bus.mul_ab;
            r_resp_err <= 1'b0;
            r_resp_id  <= r_sel;
            r_state    <= S_RESP;
          end else if (w_timeout) begin
            r_resp_ab  <= '0;
            r_resp_err <= 1'b1;
            r_resp_id  <= r_sel;
            r_state    <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE && w_found && !reset) ? (N'(1) << w_win) : '0;
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_ab    = r_resp_ab;
  assign bus.resp_err   = r_resp_err;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.mul_reset  = reset | (r_state == S_CLEAR);
  assign bus.mul_enable = (r_state == S_RUN);
  assign bus.mul_a      = r_mul_a;
  assign bus.mul_b      = r_mul_b;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter with a behavioural multiplier whose
// done latency is set per job (0 means it never finishes).
module tb_booth_mul_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  booth_mul_arbiter_if #(.N(N), .WIDTH(W)) bus ();

  booth_mul_arbiter #(.N(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks   = 0;
  int n_pass     = 0;
  int done_delay = 0;
  int model_cnt  = 0;

  // Multiplier model: done rises on RUN cycle number done_delay.
  always @(posedge clk) begin
    if (bus.mul_reset) begin
      model_cnt    <= 0;
      bus.mul_done <= 1'b0;
      bus.mul_ab   <= '0;
    end else if (bus.mul_enable && !bus.mul_done) begin
      model_cnt <= model_cnt + 1;
      if (done_delay != 0 && model_cnt + 1 == done_delay) begin
        bus.mul_done <= 1'b1;
        bus.mul_ab   <= bus.mul_a * bus.mul_b;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[id*W +: W] = a;
    bus.req_b[id*W +: W] = b;
  endtask

  task automatic wait_grant(output logic [N-1:0] g);
    #1;
    for (int i = 0; i < 100; i++) begin
      if (bus.req_ready != '0) break;
      @(posedge clk); #1;
    end
    if (bus.req_ready == '0) check("grant_wait", 64'(bus.req_ready != '0), 64'd1);
    g = bus.req_ready;
  endtask

  task automatic wait_resp(output int lat, output logic [1:0] id,
                           output logic [15:0] ab, output logic err);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.resp_valid) break;
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.resp_valid) check("resp_wait", 64'(bus.resp_valid), 64'd1);
    id  = bus.resp_id;
    ab  = bus.resp_ab;
    err = bus.resp_err;
  endtask

  // Full job on one requester; exp_lat counts cycles from the grant cycle to RESP.
  task automatic run_job(input string tag, input int id, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int dly, input logic [15:0] exp_ab,
                         input logic exp_err, input int exp_lat);
    logic [N-1:0] g;
    logic [1:0]   rid;
    logic [15:0]  rab;
    logic         rerr;
    int           lat;
    @(negedge clk);
    done_delay = dly;
    set_req(id, a, b);
    bus.req_valid[id] = 1'b1;
    wait_grant(g);
    check({tag, "_ready"}, 64'(g), 64'(N'(1) << id));
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
    check({tag, "_clear_pulse"}, 64'(bus.mul_reset), 64'd1);
    check({tag, "_mul_a"}, 64'(bus.mul_a), 64'(a));
    check({tag, "_mul_b"}, 64'(bus.mul_b), 64'(b));
    @(posedge clk); #1;
    check({tag, "_run_enable"}, 64'({bus.mul_reset, bus.mul_enable}), 64'b01);
    wait_resp(lat, rid, rab, rerr);
    lat = lat + 2;
    $display("%s: id=%0d a=0x%02h b=0x%02h ab=0x%04h err=%0d lat=%0d", tag, rid, a, b, rab, rerr, lat);
    check({tag, "_id"}, 64'(rid), 64'(id));
    check({tag, "_ab"}, 64'(rab), 64'(exp_ab));
    check({tag, "_err"}, 64'(rerr), 64'(exp_err));
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    @(posedge clk); #1;
    check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] g;
    logic [1:0]   rid;
    logic [15:0]  rab;
    logic         rerr;
    logic         seen;
    int           lat;
    logic [15:0]  rr_exp [5];
    rr_exp = '{16'h0003, 16'h0006, 16'h0009, 16'h000C, 16'h0003};

    bus.req_valid = 4'hF;
    bus.req_a     = '0;
    bus.req_b     = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_mul_reset", 64'(bus.mul_reset), 64'd1);
    check("rst_mul_enable", 64'(bus.mul_enable), 64'd0);
    check("rst_resp", 64'({bus.resp_valid, bus.resp_err, bus.resp_id}), 64'd0);
    check("rst_resp_ab", 64'(bus.resp_ab), 64'd0);
    check("rst_mul_ab", 64'({bus.mul_a, bus.mul_b}), 64'd0);
    bus.req_valid = '0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("idle_mul_reset", 64'(bus.mul_reset), 64'd0);
    check("idle_busy", 64'(bus.busy), 64'd0);

    // Everyone requesting continuously: grants rotate 0,1,2,3,0.
    @(negedge clk);
    done_delay = 1;
    for (int i = 0; i < N; i++) set_req(i, W'(i + 1), 8'd3);
    bus.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      check("rr_grant", 64'(g), 64'(N'(1) << (k % N)));
      check("rr_onehot", 64'($countones(g)), 64'd1);
      @(posedge clk); #1;
      if (k == 4) bus.req_valid = '0;
      wait_resp(lat, rid, rab, rerr);
      $display("rr%0d: id=%0d ab=0x%04h err=%0d", k, rid, rab, rerr);
      check("rr_id", 64'(rid), 64'(k % N));
      check("rr_ab", 64'(rab), 64'(rr_exp[k]));
    end

    run_job("single", 2, 8'h0F, 8'h11, 5, 16'h00FF, 1'b0, 8);

    // Pointer is 3: requesters 1 and 3 pending, 3 goes first.
    @(negedge clk);
    done_delay = 1;
    set_req(1, 8'd2, 8'd5);
    set_req(3, 8'd4, 8'd4);
    bus.req_valid = 4'b1010;
    wait_grant(g);
    check("ptr3_grant", 64'(g), 64'b1000);
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b0;
    wait_resp(lat, rid, rab, rerr);
    $display("ptr3_first: id=%0d ab=0x%04h err=%0d", rid, rab, rerr);
    check("ptr3_id", 64'(rid), 64'd3);
    check("ptr3_ab", 64'(rab), 64'h0010);
    wait_grant(g);
    check("ptr3_second_grant", 64'(g), 64'b0010);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_resp(lat, rid, rab, rerr);
    $display("ptr3_second: id=%0d ab=0x%04h err=%0d", rid, rab, rerr);
    check("ptr3_second_ab", 64'(rab), 64'h000A);

    run_job("ptr_to0", 3, 8'd1, 8'd1, 1, 16'h0001, 1'b0, 4);

    // Pointer is 0: requesters 1 and 2 pending, 1 goes first.
    @(negedge clk);
    set_req(2, 8'd9, 8'd9);
    bus.req_valid = 4'b0110;
    wait_grant(g);
    check("ptr0_grant", 64'(g), 64'b0010);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_resp(lat, rid, rab, rerr);
    $display("ptr0: id=%0d ab=0x%04h err=%0d", rid, rab, rerr);
    check("ptr0_id", 64'(rid), 64'd1);

    run_job("timeout", 2, 8'h33, 8'h44, 0, 16'h0000, 1'b1, 18);
    run_job("after_to", 0, 8'h12, 8'h03, 3, 16'h0036, 1'b0, 6);
    run_job("done_at_to", 1, 8'h10, 8'h10, 15, 16'h0100, 1'b0, 18);

    // Reset asserted mid-RUN abandons the job.
    @(negedge clk);
    done_delay = 0;
    set_req(1, 8'h21, 8'h02);
    bus.req_valid = 4'b0010;
    wait_grant(g);
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_busy", 64'(bus.busy), 64'd0);
    check("mid_mul_ctl", 64'({bus.mul_reset, bus.mul_enable}), 64'b10);
    check("mid_mul_ab", 64'({bus.mul_a, bus.mul_b}), 64'd0);
    check("mid_resp", 64'({bus.resp_valid, bus.resp_err, bus.resp_id}), 64'd0);
    check("mid_resp_ab", 64'(bus.resp_ab), 64'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | bus.resp_valid;
    end
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | bus.resp_valid;
    end
    check("mid_no_resp", 64'(seen), 64'd0);
    $display("reset_mid_job: resp_seen=%0d", seen);

    run_job("post_reset", 0, 8'h07, 8'h09, 2, 16'h003F, 1'b0, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
